// File: rtl/ex_data_sync_fifo.sv
// Single-clock 2048x8 FIFO, inferred dual-port RAM plus 12-bit pointers; 1-cycle read latency.
// Writes while full and reads while empty are silently dropped; all flags registered from next-state occupancy.
module ex_data_sync_fifo #(
  parameter int DEPTH_WIDTH      = 11,
  parameter int DATA_WIDTH       = 8,
  parameter int ALMOST_FULL_NUM  = 1460,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_CNT = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] AF_TH    = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_TH    = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic [DEPTH_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   count_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   wr_full_q, wr_full_d;
  logic                   rd_empty_q, rd_empty_d;
  logic                   almost_full_q, almost_full_d;
  logic                   almost_empty_q, almost_empty_d;
  logic                   wr_acc, rd_acc;

  always_comb begin
    wr_acc         = wr_en & ~wr_full_q;
    rd_acc         = rd_en & ~rd_empty_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    rd_data_d      = rd_data_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
    end
    // Pointer difference wraps correctly because pointers carry one extra bit
    count_d        = wr_ptr_d - rd_ptr_d;
    wr_full_d      = (count_d == FULL_CNT);
    rd_empty_d     = (count_d == '0);
    almost_full_d  = (count_d >= AF_TH);
    almost_empty_d = (count_d <= AE_TH);
  end

  // Storage has no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rd_data_q      <= '0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_data_q      <= rd_data_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign wr_full      = wr_full_q;
  assign rd_empty     = rd_empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_ex_data_sync_fifo.sv
// Directed bench for ex_data_sync_fifo: fill/drain boundaries, thresholds, simultaneous access, reset.
module tb_ex_data_sync_fifo;

  logic       clk = 1'b0;
  logic       tb_rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       wr_full;
  logic       almost_full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic       almost_empty;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] rd_exp;

  ex_data_sync_fifo dut (
    .clk          (clk),
    .tb_rst       (tb_rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_full      (wr_full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".rd_data"},      {24'd0, rd_data}, {24'd0, rd_exp});
    chk({tag, ".wr_full"},      {31'd0, wr_full}, {31'd0, (n == 2048)});
    chk({tag, ".rd_empty"},     {31'd0, rd_empty}, {31'd0, (n == 0)});
    chk({tag, ".almost_full"},  {31'd0, almost_full}, {31'd0, (n >= 1460)});
    chk({tag, ".almost_empty"}, {31'd0, almost_empty}, {31'd0, (n <= 4)});
  endtask

  // One clock with the given inputs; reference queue updated with accept rules, outputs checked #1 after the edge
  task automatic step(input string tag, input logic we, input logic re, input logic [7:0] wd);
    bit aw, ar;
    wr_en   = we;
    rd_en   = re;
    wr_data = wd;
    aw = we && (q.size() < 2048);
    ar = re && (q.size() != 0);
    if (ar) rd_exp = q.pop_front();
    if (aw) q.push_back(wd);
    @(posedge clk);
    #1;
    chk_all(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    tb_rst  = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    rd_exp  = 8'h00;

    #200;
    chk("rst.rd_empty",     {31'd0, rd_empty},     32'd1);
    chk("rst.almost_empty", {31'd0, almost_empty}, 32'd1);
    chk("rst.wr_full",      {31'd0, wr_full},      32'd0);
    chk("rst.almost_full",  {31'd0, almost_full},  32'd0);
    chk("rst.rd_data",      {24'd0, rd_data},      32'd0);
    tb_rst = 1'b0;

    // Fill with 0xFF, 0xFE, ...; 2049th write must be dropped
    for (int i = 0; i < 2049; i++) begin
      step("fill", 1'b1, 1'b0, 8'hFF - i[7:0]);
      if (i == 3)    chk("fill4.almost_empty",    {31'd0, almost_empty}, 32'd1);
      if (i == 4)    chk("fill5.almost_empty",    {31'd0, almost_empty}, 32'd0);
      if (i == 1458) chk("fill1459.almost_full",  {31'd0, almost_full},  32'd0);
      if (i == 1459) chk("fill1460.almost_full",  {31'd0, almost_full},  32'd1);
      if (i == 2046) chk("fill2047.wr_full",      {31'd0, wr_full},      32'd0);
      if (i == 2047) chk("fill2048.wr_full",      {31'd0, wr_full},      32'd1);
      if (i == 2048) chk("fill2049.wr_full",      {31'd0, wr_full},      32'd1);
    end

    // Drain; 2049th read is ignored and rd_data holds 0x00
    for (int k = 1; k <= 2049; k++) begin
      step("drain", 1'b0, 1'b1, 8'h00);
      if (k <= 2048) chk("drain.data", {24'd0, rd_data}, {24'd0, 8'hFF - 8'(k - 1)});
      if (k == 588)  chk("drain588.almost_full",   {31'd0, almost_full},  32'd1);
      if (k == 589)  chk("drain589.almost_full",   {31'd0, almost_full},  32'd0);
      if (k == 2043) chk("drain2043.almost_empty", {31'd0, almost_empty}, 32'd0);
      if (k == 2044) chk("drain2044.almost_empty", {31'd0, almost_empty}, 32'd1);
      if (k == 2048) chk("drain2048.rd_empty",     {31'd0, rd_empty},     32'd1);
      if (k == 2049) chk("drain2049.rd_data",      {24'd0, rd_data},      32'd0);
    end

    // Steady simultaneous read/write at count 10
    for (int i = 0; i < 10; i++) step("pre10", 1'b1, 1'b0, 8'h10 + i[7:0]);
    for (int j = 0; j < 20; j++) begin
      step("simul", 1'b1, 1'b1, 8'h20 + j[7:0]);
      chk("simul.data", {24'd0, rd_data},
          (j < 10) ? 32'h10 + j : 32'h20 + (j - 10));
      chk("simul.count", q.size(), 32'd10);
    end
    for (int i = 0; i < 10; i++) begin
      step("post10", 1'b0, 1'b1, 8'h00);
      chk("post10.data", {24'd0, rd_data}, 32'h2A + i);
    end

    // Full with simultaneous access: read wins, 0xAA never stored
    for (int i = 0; i < 2048; i++) step("refill", 1'b1, 1'b0, i[7:0]);
    chk("refill.wr_full", {31'd0, wr_full}, 32'd1);
    step("full_rw", 1'b1, 1'b1, 8'hAA);
    chk("full_rw.rd_data", {24'd0, rd_data}, 32'h00);
    chk("full_rw.wr_full", {31'd0, wr_full}, 32'd0);
    for (int i = 1; i < 2048; i++) step("drain2", 1'b0, 1'b1, 8'h00);
    chk("drain2.last", {24'd0, rd_data}, 32'hFF);
    chk("drain2.rd_empty", {31'd0, rd_empty}, 32'd1);

    // Empty with simultaneous access: write wins, no bypass
    step("empty_rw", 1'b1, 1'b1, 8'h5C);
    chk("empty_rw.rd_data", {24'd0, rd_data}, 32'hFF);
    chk("empty_rw.rd_empty", {31'd0, rd_empty}, 32'd0);
    step("empty_rw.read", 1'b0, 1'b1, 8'h00);
    chk("empty_rw.read.data", {24'd0, rd_data}, 32'h5C);

    // Reset mid-operation discards contents
    for (int i = 0; i < 7; i++) step("prerst", 1'b1, 1'b0, 8'hC0 + i[7:0]);
    step("prerst.read", 1'b0, 1'b1, 8'h00);
    chk("prerst.read.data", {24'd0, rd_data}, 32'hC0);
    tb_rst = 1'b1;
    #2;
    q.delete();
    rd_exp = 8'h00;
    chk_all("midrst");
    tb_rst = 1'b0;
    step("postrst.idle", 1'b0, 1'b1, 8'h00);
    step("postrst.wr", 1'b1, 1'b0, 8'h3E);
    step("postrst.rd", 1'b0, 1'b1, 8'h00);
    chk("postrst.data", {24'd0, rd_data}, 32'h3E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
